edge_event_arbiter: RTL

Multi-channel edge-event scheduler. Each of N_CH asynchronous inputs is synchronised and edge-detected in a per-channel mode: rising, falling, both, or off. Detected edges are held as one-deep pending events per channel. The pending events share a single valid/ready event port under round-robin arbitration. The block sits between raw external strobes (buttons, sensor flags) and a single event consumer such as an interrupt or sequencer block.

---
 rtl/edge_evt_pkg.sv | 9 +
 rtl/edge_sync_detect.sv | 39 +++
 rtl/edge_event_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/edge_evt_pkg.sv
// Shared encodings for the edge-event scheduler: per-channel edge_mode values.
package edge_evt_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_sync_detect.sv
// One channel front end: multi-flop synchroniser, previous-level flop and
// mode-gated rise/fall pulse generation.
module edge_sync_detect
    import edge_evt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       data_in,
    input  logic [1:0] mode,
    output logic       rise,
    output logic       fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   level_p1;
    logic                   sync_out;
    logic                   rise_en;
    logic                   fall_en;

    // Stage 0: synchroniser chain; stage 1: previous synchronised level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_p0  <= '0;
            level_p1 <= 1'b0;
        end else begin
            sync_p0  <= {sync_p0[SYNC_STAGES-2:0], data_in};
            level_p1 <= sync_out;
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];
    assign rise_en  = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign fall_en  = (mode == MODE_FALL) || (mode == MODE_BOTH);
    assign rise     = sync_out & ~level_p1 & rise_en;
    assign fall     = ~sync_out & level_p1 & fall_en;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel one-deep pending slots,
// sticky overflow flags and a round-robin valid/ready event output.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_CH-1:0]         data_in,
    input  logic [2*N_CH-1:0]       edge_mode,
    output logic                    event_valid,
    input  logic                    event_ready,
    output logic [$clog2(N_CH)-1:0] event_ch,
    output logic                    event_rising,
    output logic [N_CH-1:0]         overflow,
    input  logic [N_CH-1:0]         overflow_clr
);

    localparam int CH_W = $clog2(N_CH);
    localparam logic [CH_W:0]   N_CH_EXT = (CH_W+1)'(N_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] ch_on;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pend_pol;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] grant_oh;
    logic [N_CH-1:0] ovf_set;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] cand;
    logic [CH_W:0]   cand_sum;
    logic            grant_vld;
    logic            load;
    logic            take;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_sync_detect #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_det (
            .clk    (clk),
            .resetn (resetn),
            .data_in(data_in[i]),
            .mode   (edge_mode[2*i +: 2]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
        assign ch_on[i] = (edge_mode[2*i +: 2] != MODE_OFF);
    end

    // A channel switched off never competes, even in the cycle its slot clears
    assign req = pend & ch_on;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand_sum = {1'b0, ptr} + (CH_W+1)'(k);
            if (cand_sum >= N_CH_EXT) begin
                cand_sum = cand_sum - N_CH_EXT;
            end
            cand = cand_sum[CH_W-1:0];
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign load = ~event_valid | event_ready;
    assign take = load & grant_vld;

    always_comb begin
        grant_oh = '0;
        if (take) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // A slot being handed to the output this cycle can accept a new edge
    assign ovf_set = (rise | fall) & pend & ~grant_oh;

    // Stage 1: pending slots and sticky overflow (set wins over clear)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend     <= '0;
            pend_pol <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!ch_on[i]) begin
                    pend[i] <= 1'b0;
                end else if (rise[i] | fall[i]) begin
                    if (!pend[i] || grant_oh[i]) begin
                        pend[i]     <= 1'b1;
                        pend_pol[i] <= rise[i];
                    end
                end else if (grant_oh[i]) begin
                    pend[i] <= 1'b0;
                end
                overflow[i] <= ovf_set[i] | (overflow[i] & ~overflow_clr[i]);
            end
        end
    end

    // Stage 2: output register and round-robin pointer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            event_valid  <= 1'b0;
            event_ch     <= '0;
            event_rising <= 1'b0;
            ptr          <= '0;
        end else if (load) begin
            event_valid <= grant_vld;
            if (grant_vld) begin
                event_ch     <= grant_idx;
                event_rising <= pend_pol[grant_idx];
                ptr          <= (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
            end
        end
    end

endmodule
